// File: rtl/river_log_mover.sv
// River log mover: owns every log position in the river lanes and advances
// them once per frame, one row per clock, with per-row move flags for frog riding.
module river_log_mover #(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_LOGS     = 1,
  parameter int SCREEN_WIDTH = 320,
  parameter int LOG_LEN      = 64,
  parameter int STEP         = 2,
  parameter int ROW_STAGGER  = 40,
  parameter int RIVER_Y0     = 32,
  parameter int ROW_H        = 32
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     frame_tick_i,
  input  logic                                     enable_i,
  input  logic [NUM_ROWS-1:0][3:0]                 row_period_i,
  input  logic [NUM_ROWS-1:0]                      row_dir_i,
  output logic [NUM_ROWS-1:0][NUM_LOGS-1:0][9:0]   log_x_o,
  output logic [NUM_ROWS-1:0][NUM_LOGS-1:0][9:0]   log_width_o,
  output logic [NUM_ROWS-1:0][9:0]                 river_rows_o,
  output logic [NUM_ROWS-1:0]                      row_moved_o,
  output logic                                     busy_o,
  output logic                                     update_done_o
);

  // state    | meaning
  // S_IDLE   | waiting for an enabled frame_tick
  // S_UPDATE | processing row row_q, one row per clock
  // S_DONE   | pass finished, update_done high for this cycle
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [10:0] SW11   = 11'(SCREEN_WIDTH);
  localparam logic [10:0] STEP11 = 11'(STEP);

  state_t                                state_q;
  logic [ROW_W-1:0]                      row_q;
  logic [NUM_ROWS-1:0][3:0]              cnt_q;
  logic [NUM_ROWS-1:0][NUM_LOGS-1:0][9:0] log_x_q;
  logic [NUM_ROWS-1:0]                   row_moved_q;

  logic [NUM_LOGS-1:0][9:0] row_x_d;
  logic [3:0]               cur_period;
  logic [3:0]               cur_cnt;
  logic                     cur_dir;
  logic                     last_row;
  logic [10:0]              x11;
  logic [10:0]              sum11;

  // Staggered start positions so lanes do not line up at power-up.
  function automatic logic [9:0] init_x(input int r, input int i);
    return 10'((i * SCREEN_WIDTH / NUM_LOGS + r * ROW_STAGGER) % SCREEN_WIDTH);
  endfunction

  // Wrapped next position of every log in the row currently being processed.
  always_comb begin
    cur_period = row_period_i[row_q];
    cur_cnt    = cnt_q[row_q];
    cur_dir    = row_dir_i[row_q];
    last_row   = (row_q == ROW_W'(NUM_ROWS - 1));
    x11        = '0;
    sum11      = '0;
    row_x_d    = '0;
    for (int i = 0; i < NUM_LOGS; i++) begin
      x11 = {1'b0, log_x_q[row_q][i]};
      if (!cur_dir) begin
        sum11 = x11 + STEP11;
        row_x_d[i] = (sum11 >= SW11) ? 10'(sum11 - SW11) : 10'(sum11);
      end else begin
        row_x_d[i] = (x11 < STEP11) ? 10'(x11 + SW11 - STEP11) : 10'(x11 - STEP11);
      end
    end
  end

  // Pass sequencer: frame counters, log positions and move flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      row_moved_q <= '0;
      for (int r = 0; r < NUM_ROWS; r++)
        for (int i = 0; i < NUM_LOGS; i++)
          log_x_q[r][i] <= init_x(r, i);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick_i && enable_i) begin
            state_q     <= S_UPDATE;
            row_q       <= '0;
            row_moved_q <= '0;
          end
        end
        S_UPDATE: begin
          if (cur_period == 4'd0) begin
            cnt_q[row_q]       <= 4'd0;
            row_moved_q[row_q] <= 1'b0;
          end else if (cur_cnt == 4'(cur_period - 4'd1)) begin
            cnt_q[row_q]       <= 4'd0;
            log_x_q[row_q]     <= row_x_d;
            row_moved_q[row_q] <= 1'b1;
          end else begin
            cnt_q[row_q]       <= cur_cnt + 4'd1;
            row_moved_q[row_q] <= 1'b0;
          end
          if (last_row) state_q <= S_DONE;
          else          row_q   <= row_q + 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Constant geometry outputs.
  always_comb begin
    log_width_o  = '0;
    river_rows_o = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      river_rows_o[r] = 10'(RIVER_Y0 + r * ROW_H);
      for (int i = 0; i < NUM_LOGS; i++)
        log_width_o[r][i] = 10'(LOG_LEN);
    end
  end

  assign log_x_o       = log_x_q;
  assign row_moved_o   = row_moved_q;
  assign busy_o        = (state_q != S_IDLE);
  assign update_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_river_log_mover.sv
// Bench for river_log_mover: two instances (two logs/row, and odd stagger for
// odd-position wraps) checked against a modular-arithmetic reference model.
module tb_river_log_mover;

  localparam int SW = 320;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;
  logic [3:0][3:0] row_period = '0;
  logic [3:0]      row_dir = '0;

  logic [3:0][1:0][9:0] log_x_a, log_w_a;
  logic [3:0][0:0][9:0] log_x_b, log_w_b;
  logic [3:0][9:0]      rows_a, rows_b;
  logic [3:0]           moved_a, moved_b;
  logic                 busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;

  int  mx[2][4][2];
  int  cnt[4];
  bit  mmoved[4];

  always #5 clk = ~clk;

  river_log_mover #(.NUM_LOGS(2)) dut_a (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .enable_i(enable),
    .row_period_i(row_period), .row_dir_i(row_dir),
    .log_x_o(log_x_a), .log_width_o(log_w_a), .river_rows_o(rows_a),
    .row_moved_o(moved_a), .busy_o(busy_a), .update_done_o(done_a));

  river_log_mover #(.NUM_LOGS(1), .ROW_STAGGER(41)) dut_b (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .enable_i(enable),
    .row_period_i(row_period), .row_dir_i(row_dir),
    .log_x_o(log_x_b), .log_width_o(log_w_b), .river_rows_o(rows_b),
    .row_moved_o(moved_b), .busy_o(busy_b), .update_done_o(done_b));

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      cnt[r] = 0;
      mmoved[r] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mx[0][r][i] = (i * SW / 2 + r * 40) % SW;
        mx[1][r][i] = (r * 41) % SW;
      end
    end
  endtask

  // One frame of the game rules: each row counts frames and moves every period-th one.
  task automatic model_pass();
    int p;
    for (int r = 0; r < 4; r++) begin
      p = int'(row_period[r]);
      if (p == 0) begin
        cnt[r] = 0;
        mmoved[r] = 1'b0;
      end else if (cnt[r] == p - 1) begin
        cnt[r] = 0;
        mmoved[r] = 1'b1;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 2; i++)
            mx[d][r][i] = row_dir[r] ? (mx[d][r][i] + SW - ST) % SW : (mx[d][r][i] + ST) % SW;
      end else begin
        cnt[r] = (cnt[r] + 1) % 16;
        mmoved[r] = 1'b0;
      end
    end
  endtask

  task automatic check_row(input string tag, input int r, input int ea0, input int ea1, input int eb);
    check_val($sformatf("%s_a[%0d][0]", tag, r), int'(log_x_a[r][0]), ea0);
    check_val($sformatf("%s_a[%0d][1]", tag, r), int'(log_x_a[r][1]), ea1);
    check_val($sformatf("%s_b[%0d]", tag, r), int'(log_x_b[r][0]), eb);
  endtask

  task automatic check_flags(input string tag, input int busy_e, input int done_e);
    check_val({tag, "_busy_a"}, int'(busy_a), busy_e);
    check_val({tag, "_busy_b"}, int'(busy_b), busy_e);
    check_val({tag, "_done_a"}, int'(done_a), done_e);
    check_val({tag, "_done_b"}, int'(done_b), done_e);
  endtask

  task automatic check_moved(input string tag);
    int em;
    em = 0;
    for (int r = 0; r < 4; r++) em |= int'(mmoved[r]) << r;
    check_val({tag, "_moved_a"}, int'(moved_a), em);
    check_val({tag, "_moved_b"}, int'(moved_b), em);
  endtask

  // Issue one frame_tick and follow the pass edge by edge.
  task automatic do_pass(input bit retick, input bit drop_en);
    int  old[2][4][2];
    bit  acc;
    int  ndone;
    old = mx;
    acc = enable;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    check_flags("start", int'(acc), 0);
    if (acc) model_pass();
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      frame_tick = retick && (c == 1);
      if (drop_en && c == 2) enable = 1'b0;
      if (done_a) ndone++;
      if (c <= 4)
        for (int r = 0; r < 4; r++) begin
          if (acc && r < c) check_row("pos", r, mx[0][r][0], mx[0][r][1], mx[1][r][0]);
          else              check_row("hold", r, old[0][r][0], old[0][r][1], old[1][r][0]);
        end
      if (c == 4) check_flags("done", int'(acc), int'(acc));
      if (c == 5) check_flags("idle", 0, 0);
    end
    check_val("done_count", ndone, int'(acc));
    check_moved("pass");
  endtask

  task automatic set_rows(input int p, input bit dir);
    for (int r = 0; r < 4; r++) begin
      row_period[r] = 4'(p);
      row_dir[r] = dir;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int r = 0; r < 4; r++)
      check_row(tag, r, mx[0][r][0], mx[0][r][1], mx[1][r][0]);
    check_flags(tag, 0, 0);
    check_moved(tag);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("rst");
    check_val("rst_x00", int'(log_x_a[0][0]), 0);
    check_val("rst_x01", int'(log_x_a[0][1]), 160);
    check_val("rst_x10", int'(log_x_a[1][0]), 40);
    check_val("rst_x11", int'(log_x_a[1][1]), 200);
    for (int r = 0; r < 4; r++) begin
      check_val($sformatf("river_row%0d", r), int'(rows_a[r]), 32 + 32 * r);
      check_val($sformatf("width%0d_0", r), int'(log_w_a[r][0]), 64);
      check_val($sformatf("width%0d_1", r), int'(log_w_a[r][1]), 64);
      check_val($sformatf("width_b%0d", r), int'(log_w_b[r][0]), 64);
    end

    // every row moves right once per frame
    enable = 1'b1;
    set_rows(1, 1'b0);
    do_pass(1'b0, 1'b0);
    check_val("all_moved", int'(moved_a), 15);

    // slow row and frozen row
    row_period[2] = 4'd3;
    row_period[3] = 4'd0;
    for (int t = 1; t <= 6; t++) begin
      do_pass(1'b0, 1'b0);
      check_val($sformatf("slow_row_t%0d", t), int'(moved_a[2]), int'(t % 3 == 0));
      check_val($sformatf("frozen_row_t%0d", t), int'(moved_a[3]), 0);
    end

    // tick while busy is dropped; paused ticks are ignored
    do_pass(1'b1, 1'b0);
    enable = 1'b0;
    do_pass(1'b0, 1'b0);
    enable = 1'b1;
    do_pass(1'b0, 1'b1);
    enable = 1'b1;

    // long runs to cross the wrap point both ways, odd and even positions
    set_rows(1, 1'b1);
    repeat (24) do_pass(1'b0, 1'b0);
    set_rows(1, 1'b0);
    repeat (165) do_pass(1'b0, 1'b0);

    // reset mid-pass while row 2 is next
    set_rows(1, 1'b0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("midrst");
    @(posedge clk); #1;
    check_reset_state("midrst_hold");
    reset = 1'b0;
    do_pass(1'b0, 1'b0);

    // randomized frames
    for (int n = 0; n < 150; n++) begin
      for (int r = 0; r < 4; r++) begin
        row_period[r] = 4'($urandom_range(0, 4));
        row_dir[r] = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 3) != 0);
      do_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
